// File: rtl/pmp_cmd_rx_pkg.sv
// rtl/pmp_cmd_rx_pkg.sv - shared constants and FSM encoding for the PMP command receiver
package pmp_cmd_rx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [7:0] REG_DECIM = 8'd0;
  localparam logic [7:0] REG_TRIG  = 8'd1;
  localparam logic [7:0] REG_POST  = 8'd2;
  localparam logic [7:0] REG_CTRL  = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

endpackage

// File: rtl/pmp_sync_edge.sv
// rtl/pmp_sync_edge.sv - two-flop synchronizer with rising-edge detect on the synchronized level
module pmp_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // All stages reset to the idle level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pmp_cmd_rx.sv
// rtl/pmp_cmd_rx.sv - receives framed register writes from the PIC parallel port into the adc_dco domain
module pmp_cmd_rx
  import pmp_cmd_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] DECIM_RST      = 16'hFFFF,
  parameter logic [15:0] POSTTRIG_RST   = 16'd4096
) (
  input  logic        adc_dco,
  input  logic        reset,
  input  logic [7:0]  pmd_in,
  input  logic        pmwrn,
  input  logic        pmcs2,
  output logic [15:0] decim_factor,
  output logic [7:0]  trig_level,
  output logic [15:0] posttrig_count,
  output logic        arm,
  output logic        force_trig,
  output logic        frame_ok,
  output logic [7:0]  err_cnt
);

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  logic          wr_rise;
  logic          accept;
  logic          err_event;
  logic [7:0]    chk_exp;

  logic          cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
  logic [7:0]    dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [15:0]   decim_q, decim_d, post_q, post_d;
  logic [7:0]    trig_q, trig_d, err_q, err_d;
  logic          arm_q, arm_d, force_q, force_d, fok_q, fok_d;

  pmp_sync_edge #(.RST_VAL(1'b1)) u_wr_sync (
    .clk  (adc_dco),
    .rst  (reset),
    .d    (pmwrn),
    .rise (wr_rise)
  );

  assign accept = wr_rise & cs_sync_q;

  always_comb begin
    cs_meta_d  = pmcs2;
    cs_sync_d  = cs_meta_q;
    dat_meta_d = pmd_in;
    dat_sync_d = dat_meta_q;
    state_d    = state_q;
    gap_d      = gap_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    decim_d    = decim_q;
    trig_d     = trig_q;
    post_d     = post_q;
    arm_d      = arm_q;
    force_d    = 1'b0;
    fok_d      = 1'b0;
    err_d      = err_q;
    err_event  = 1'b0;
    chk_exp    = SYNC_BYTE ^ addr_q ^ dhi_q ^ dlo_q;

    // An accepted byte always restarts the gap count, so it beats a same-cycle timeout.
    if (accept) begin
      gap_d = '0;
      unique case (state_q)
        ST_IDLE: if (dat_sync_q == SYNC_BYTE) state_d = ST_ADDR;
        ST_ADDR: begin addr_d = dat_sync_q; state_d = ST_DHI; end
        ST_DHI:  begin dhi_d  = dat_sync_q; state_d = ST_DLO; end
        ST_DLO:  begin dlo_d  = dat_sync_q; state_d = ST_CHK; end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (dat_sync_q == chk_exp && addr_q <= REG_CTRL) begin
            fok_d = 1'b1;
            unique case (addr_q)
              REG_DECIM: decim_d = {dhi_q, dlo_q};
              REG_TRIG:  trig_d  = dlo_q;
              REG_POST:  post_d  = {dhi_q, dlo_q};
              REG_CTRL: begin
                arm_d   = dlo_q[0];
                force_d = dlo_q[1];
              end
              default: ;
            endcase
          end else begin
            err_event = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        gap_d     = '0;
        err_event = 1'b1;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end

    if (err_event && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge adc_dco or posedge reset) begin
    if (reset) begin
      cs_meta_q  <= 1'b0;
      cs_sync_q  <= 1'b0;
      dat_meta_q <= 8'h00;
      dat_sync_q <= 8'h00;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      addr_q     <= 8'h00;
      dhi_q      <= 8'h00;
      dlo_q      <= 8'h00;
      decim_q    <= DECIM_RST;
      trig_q     <= 8'h00;
      post_q     <= POSTTRIG_RST;
      arm_q      <= 1'b0;
      force_q    <= 1'b0;
      fok_q      <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      cs_meta_q  <= cs_meta_d;
      cs_sync_q  <= cs_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      decim_q    <= decim_d;
      trig_q     <= trig_d;
      post_q     <= post_d;
      arm_q      <= arm_d;
      force_q    <= force_d;
      fok_q      <= fok_d;
      err_q      <= err_d;
    end
  end

  assign decim_factor   = decim_q;
  assign trig_level     = trig_q;
  assign posttrig_count = post_q;
  assign arm            = arm_q;
  assign force_trig     = force_q;
  assign frame_ok       = fok_q;
  assign err_cnt        = err_q;

endmodule

// File: doc/pmp_cmd_rx.md
PMP_CMD_RX -- requirements
Module: pmp_cmd_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, max adc_dco cycles allowed between bytes of one frame.
REQ-003 SHALL have parameter DECIM_RST, default 16'hFFFF, reset value of decim_factor.
REQ-004 SHALL have parameter POSTTRIG_RST, default 16'd4096, reset value of posttrig_count.
REQ-005 SHALL have port adc_dco, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port pmd_in, input, 8, PIC PMP data bus, asynchronous to adc_dco.
REQ-008 SHALL have port pmwrn, input, 1, PIC write strobe, active-low, asynchronous.
REQ-009 SHALL have port pmcs2, input, 1, PIC chip select for this block, active-high, asynchronous.
REQ-010 SHALL have port decim_factor, output, 16, committed register 0.
REQ-011 SHALL have port trig_level, output, 8, signed committed register 1 (low byte).
REQ-012 SHALL have port posttrig_count, output, 16, committed register 2.
REQ-013 SHALL have port arm, output, 1, committed register 3 bit0.
REQ-014 SHALL have port force_trig, output, 1, one-cycle pulse on register 3 write with bit1=1.
REQ-015 SHALL have port frame_ok, output, 1, one-cycle pulse per committed frame.
REQ-016 SHALL have port err_cnt, output, 8, count of rejected frames, saturating at 8'hFF.

Function
REQ-017 pmwrn, pmcs2, pmd_in SHALL each pass through two flops on adc_dco before use.
REQ-018 A byte SHALL be accepted on synchronized pmwrn 0->1 transition while synchronized pmcs2=1, using synchronized pmd_in of that same cycle; no acceptance otherwise.
REQ-019 Frame SHALL be: SYNC_BYTE, ADDR, DHI, DLO, CHK, where CHK = SYNC_BYTE ^ ADDR ^ DHI ^ DLO.
REQ-020 FSM states SHALL be IDLE, ADDR, DHI, DLO, CHK; each accepted byte advances one state, CHK returns to IDLE.
REQ-021 In IDLE, a byte not equal to SYNC_BYTE SHALL be discarded silently (no err_cnt change).
REQ-022 On CHK match and ADDR in 0..3, register SHALL be written with {DHI,DLO} (trig_level takes DLO; reg3 uses DLO[1:0]) and frame_ok pulsed, both exactly 1 cycle after the CHK acceptance cycle.
REQ-023 On CHK mismatch or ADDR > 3, nothing SHALL be written and err_cnt SHALL increment.
REQ-024 force_trig SHALL pulse once per valid reg3 write with DLO[1]=1; bit1 is never stored.
REQ-025 Outside IDLE, a byte-gap counter SHALL reset on each accepted byte; reaching TIMEOUT_CYCLES SHALL return FSM to IDLE, discard partial frame, increment err_cnt.
REQ-026 pmcs2 deassertion mid-frame SHALL NOT abort the frame; only timeout or completion ends it.
REQ-027 Timeout and byte acceptance in the same cycle: acceptance SHALL win.
REQ-028 err_cnt SHALL hold 8'hFF once reached; simultaneous events never double-increment.

Reset
REQ-029 Reset SHALL set FSM=IDLE, sync flops to idle levels (pmwrn=1, pmcs2=0, data=0), decim_factor=DECIM_RST, trig_level=0, posttrig_count=POSTTRIG_RST, arm=0, force_trig=0, frame_ok=0, err_cnt=0, gap counter=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; first post-reset byte is treated as in IDLE.

Structure
REQ-031 Shared package SHALL hold register address constants (REG_DECIM=0, REG_TRIG=1, REG_POST=2, REG_CTRL=3), SYNC_BYTE default, FSM state encoding.
REQ-032 One sub-module, pmp_sync_edge (2-flop synchronizer plus rising-edge detect), SHALL be used for the strobe path.

Verification
REQ-033 Frame A5,00,12,34,(A5^00^12^34=83) -> decim_factor=16'h1234, frame_ok pulse, err_cnt=0.
REQ-034 Frame A5,03,00,03,A5 -> arm=1, force_trig single 1-cycle pulse, arm stays 1.
REQ-035 Frame A5,02,10,00,FF (bad CHK) -> posttrig_count stays 4096, err_cnt=1, no frame_ok.
REQ-036 Bytes A5,01 then 1024-cycle gap -> err_cnt=1, FSM IDLE; next full frame A5,01,00,80,24 -> trig_level=8'h80.
REQ-037 Stray bytes 00,FF before valid frame -> ignored, err_cnt=0, frame committed normally.
REQ-038 Reset asserted after A5,00,AB -> all outputs at reset values; subsequent valid frame commits.
